// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b,
// one bit per clock, LSB first, using one full-adder cell with inverted b
// and a borrow flip-flop.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active-high
//   start      - operation request, sampled only while idle
//   a, b       - minuend / subtrahend, captured on accepted start
//   busy       - high whenever the unit is not idle
//   done       - one-cycle pulse, result valid from this cycle
//   diff       - a - b mod 2^WIDTH
//   borrow_out - 1 iff a < b (unsigned)
//   overflow   - signed overflow of a - b
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_r_next;
    logic             w_last;

    // Full-subtractor cell: a + ~b + 1 expressed with an active-high borrow
    assign w_x       = r_a_sr[0];
    assign w_y       = r_b_sr[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_r_next  = {w_d, r_r_sr[WIDTH-1:1]};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // Control FSM and datapath; result registers only update on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_r_sr   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_r_sr <= w_r_next;
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff   <= w_r_next;
                        r_borrow <= w_br_next;
                        // Overflow only possible when operand signs differ
                        r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;

endmodule
